ldpc_uart_link: RTL and testbench
=================================

LDPC_UART_LINK -- requirements
Module: ldpc_uart_link

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416; clk cycles per line bit, legal range 16..65535.
REQ-002 Parameter STOP_BITS, default 1; number of stop bits, legal values 1 or 2, applies to both TX and RX.
REQ-003 Parameter ECC_EN, default 1; 1 = (16,8) LDPC frame, 0 = plain 8-bit frame with no parity byte and no correction.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tx_data  input  8  message byte to send.
REQ-007 tx_valid  input  1  tx_data is offered.
REQ-008 tx_ready  output  1  TX is idle and will accept on this cycle.
REQ-009 tx  output  1  serial line out, idle high.
REQ-010 rx  input  1  serial line in, asynchronous to clk.
REQ-011 rx_data  output  8  decoded (corrected) message byte.
REQ-012 rx_valid  output  1  one-cycle pulse: rx_data and the flags below are valid.
REQ-013 rx_corrected  output  1  a single-bit error was corrected in this frame.
REQ-014 rx_uncorrectable  output  1  nonzero syndrome matched no single-bit pattern.
REQ-015 rx_frame_err  output  1  a stop bit was sampled low.

Function
REQ-016 Encoding SHALL be codeword c[15:8]=m, with c7=m7^m5^m3^m2, c6=m6^m5^m2^m1, c5=m7^m5^m4^m1, c4=m6^m4^m3^m0, c3=m7^m5^m4^m2^m0, c2=m6^m3^m2^m1^m0, c1=m7^m4^m3^m1^m0, c0=m6^m5^m4^m1^m0.
REQ-017 The baud counter SHALL be a free-running CLKS_PER_BIT counter per direction; TX bit period = exactly CLKS_PER_BIT clk cycles.
REQ-018 TX handshake: a transfer occurs on the clk edge where tx_valid && tx_ready; the codeword is latched on that edge and tx_ready deasserts the next cycle.
REQ-019 TX FSM IDLE->START->DATA->STOP->IDLE: start bit 0, then 16 bits (8 if ECC_EN=0) LSB first (c0 first), then STOP_BITS high bits; tx_ready reasserts on the cycle after the last stop bit ends.
REQ-020 tx_data and tx_valid changes outside the accept edge SHALL have no effect on a frame in flight.
REQ-021 rx SHALL pass through a 2-flop synchroniser before use.
REQ-022 RX FSM IDLE->START->DATA->STOP->DECODE->IDLE: falling edge in IDLE starts a counter; the line is sampled at CLKS_PER_BIT/2 (mid-bit) and every CLKS_PER_BIT thereafter.
REQ-023 Start bit sampled high at mid-bit SHALL be treated as a glitch: return to IDLE with no output.
REQ-024 Data bits SHALL be shifted in LSB first into a 16-bit register (8-bit if ECC_EN=0).
REQ-025 With STOP_BITS=2, a low on either stop sample SHALL set rx_frame_err; RX returns to IDLE only after the line is seen high.
REQ-026 Syndrome s[7:0] = parity recomputed from received c[15:8] XOR received c[7:0].
REQ-027 Decode: s=0 -> no flags; s one-hot -> parity-bit error, data unchanged, rx_corrected=1; s equal to column m7..m0 = AA,55,E9,3B,96,CC,67,1F (hex) -> invert that data bit, rx_corrected=1; otherwise rx_uncorrectable=1, rx_data=raw received byte.
REQ-028 rx_valid SHALL pulse for exactly one clk, one cycle after the final stop sample; rx_data and flags hold until the next rx_valid.
REQ-029 On framing error, rx_valid SHALL still pulse with rx_frame_err=1 and decode flags computed normally.
REQ-030 With ECC_EN=0, rx_corrected and rx_uncorrectable SHALL be constant 0.
REQ-031 TX and RX SHALL operate fully independently; simultaneous send and receive, including tx looped to rx, SHALL be supported.

Reset
REQ-032 rst SHALL force both FSMs to IDLE and clear all counters.
REQ-033 Reset output values: tx=1, tx_ready=1 (from the first cycle after deassertion), rx_data=0, and all rx_* flags=0.
REQ-034 rst asserted mid-frame SHALL abort the frame with no rx_valid, and tx SHALL go high immediately.

Verification
REQ-035 Loopback tx->rx, send 0xFF -> line carries 0, then bits of 0xFF0F LSB first, then 1; rx_data=0xFF, rx_valid pulse, all flags 0.
REQ-036 Inject codeword 0xDF0F on rx -> rx_data=0xFF, rx_corrected=1.
REQ-037 Inject 0xFF0E (c0 flipped) -> rx_data=0xFF, rx_corrected=1.
REQ-038 Inject 0xFF0C (syndrome 0x03) -> rx_data=0xFF, rx_uncorrectable=1.
REQ-039 Inject 0x0000 with the stop bit low -> rx_data=0x00, rx_frame_err=1; a 3-cycle low glitch on idle rx -> no rx_valid.
REQ-040 Assert rst mid-TX at bit 7 -> tx=1 and tx_ready=1 after release; the next frame for 0x5A is received correctly.

Source files
------------

// File: rtl/ldpc_uart_link.sv
// UART link carrying one message byte per frame, optionally protected by a
// (16,8) LDPC code that corrects any single-bit error on the receive side.
`timescale 1ns/1ps
module ldpc_uart_link #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int STOP_BITS    = 1,
    parameter int ECC_EN       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_corrected,
    output logic       rx_uncorrectable,
    output logic       rx_frame_err
);
    localparam int          NBITS     = (ECC_EN != 0) ? 16 : 8;
    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] MID_CNT   = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [4:0]  LAST_DATA = 5'(NBITS - 1);
    localparam logic [4:0]  LAST_STOP = 5'(STOP_BITS - 1);
    // Parity row masks, byte i selects the message bits feeding c[i].
    localparam logic [63:0] ROW_MASKS = {8'hAC, 8'h66, 8'hB2, 8'h59, 8'hB5, 8'h4F, 8'h9B, 8'h73};

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DECODE} rx_state_t;

    tx_state_t        r_tx_state, w_tx_state_next;
    logic [15:0]      r_tx_cnt;
    logic [4:0]       r_tx_bit;
    logic [NBITS-1:0] r_tx_shift;
    logic [NBITS-1:0] w_tx_frame;
    logic             w_tx_tick;

    rx_state_t        r_rx_state, w_rx_state_next;
    logic [15:0]      r_rx_cnt;
    logic [4:0]       r_rx_bit;
    logic [NBITS-1:0] r_rx_shift;
    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic             r_ferr_acc;
    logic             w_rx_tick, w_rx_done;
    logic [7:0]       w_dec_data;
    logic             w_dec_corr, w_dec_unc;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid, r_rx_corr, r_rx_unc, r_rx_ferr;

    generate
        if (ECC_EN != 0) begin : g_ecc
            logic [7:0] w_tx_par, w_rx_calc, w_syn, w_col_hit, w_rx_msg;
            logic       w_onehot;
            assign w_rx_msg = r_rx_shift[15:8];
            for (genvar gi = 0; gi < 8; gi++) begin : g_bit
                localparam logic [7:0] COL = {ROW_MASKS[56+gi], ROW_MASKS[48+gi], ROW_MASKS[40+gi],
                                              ROW_MASKS[32+gi], ROW_MASKS[24+gi], ROW_MASKS[16+gi],
                                              ROW_MASKS[8+gi],  ROW_MASKS[gi]};
                assign w_tx_par[gi]  = ^(tx_data  & ROW_MASKS[gi*8 +: 8]);
                assign w_rx_calc[gi] = ^(w_rx_msg & ROW_MASKS[gi*8 +: 8]);
                assign w_col_hit[gi] = (w_syn == COL);
            end
            assign w_tx_frame = {tx_data, w_tx_par};
            assign w_syn      = w_rx_calc ^ r_rx_shift[7:0];
            assign w_onehot   = (w_syn != 8'd0) && ((w_syn & (w_syn - 8'd1)) == 8'd0);
            // Columns are distinct and never one-hot, so at most one hit bit is set.
            assign w_dec_data = w_rx_msg ^ w_col_hit;
            assign w_dec_corr = w_onehot || (|w_col_hit);
            assign w_dec_unc  = (w_syn != 8'd0) && !w_dec_corr;
        end else begin : g_plain
            assign w_tx_frame = tx_data;
            assign w_dec_data = r_rx_shift;
            assign w_dec_corr = 1'b0;
            assign w_dec_unc  = 1'b0;
        end
    endgenerate

    assign w_tx_tick = (r_tx_cnt == LAST_CNT);
    assign tx_ready  = (r_tx_state == TX_IDLE);
    assign tx        = (r_tx_state == TX_START) ? 1'b0 :
                       (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (tx_valid) w_tx_state_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_state_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit == LAST_DATA) w_tx_state_next = TX_STOP;
            TX_STOP:  if (w_tx_tick && r_tx_bit == LAST_STOP) w_tx_state_next = TX_IDLE;
            default:  w_tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 5'd0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_state_next;
            if (r_tx_state == TX_IDLE && tx_valid)
                r_tx_shift <= w_tx_frame;
            if (w_tx_state_next != r_tx_state || r_tx_state == TX_IDLE) begin
                r_tx_cnt <= 16'd0;
                r_tx_bit <= 5'd0;
            end else if (w_tx_tick) begin
                r_tx_cnt <= 16'd0;
                r_tx_bit <= r_tx_bit + 5'd1;
                if (r_tx_state == TX_DATA)
                    r_tx_shift <= r_tx_shift >> 1;
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_tick = (r_rx_cnt == LAST_CNT);
    assign w_rx_done = (r_rx_state == RX_STOP) && w_rx_tick && (r_rx_bit == LAST_STOP);

    // Start needs a falling edge, so a frame ending on a low stop waits for the line to rise.
    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:   if (r_rx_prev && !r_rx_sync) w_rx_state_next = RX_START;
            RX_START:  if (r_rx_cnt == MID_CNT) w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_rx_tick && r_rx_bit == LAST_DATA) w_rx_state_next = RX_STOP;
            RX_STOP:   if (w_rx_done) w_rx_state_next = RX_DECODE;
            RX_DECODE: w_rx_state_next = RX_IDLE;
            default:   w_rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 5'd0;
            r_rx_shift <= '0;
            r_ferr_acc <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_corr  <= 1'b0;
            r_rx_unc   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_valid <= 1'b0;
            if (w_rx_state_next != r_rx_state || r_rx_state == RX_IDLE) begin
                r_rx_cnt <= 16'd0;
                r_rx_bit <= 5'd0;
            end else if (w_rx_tick) begin
                r_rx_cnt <= 16'd0;
                r_rx_bit <= r_rx_bit + 5'd1;
            end else begin
                r_rx_cnt <= r_rx_cnt + 16'd1;
            end
            if (r_rx_state == RX_START)
                r_ferr_acc <= 1'b0;
            if (r_rx_state == RX_DATA && w_rx_tick)
                r_rx_shift <= {r_rx_sync, r_rx_shift[NBITS-1:1]};
            if (r_rx_state == RX_STOP && w_rx_tick && !r_rx_sync)
                r_ferr_acc <= 1'b1;
            if (w_rx_done) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_dec_data;
                r_rx_corr  <= w_dec_corr;
                r_rx_unc   <= w_dec_unc;
                r_rx_ferr  <= r_ferr_acc || !r_rx_sync;
            end
        end
    end

    assign rx_data          = r_rx_data;
    assign rx_valid         = r_rx_valid;
    assign rx_corrected     = r_rx_corr;
    assign rx_uncorrectable = r_rx_unc;
    assign rx_frame_err     = r_rx_frame_err_w();

    function automatic logic r_rx_frame_err_w();
        return r_rx_ferr;
    endfunction
endmodule

// File: tb/tb_ldpc_uart_link.sv
// Directed bench for ldpc_uart_link: loopback frames, injected codewords with
// hand-computed decode results, framing error, start glitch and mid-frame reset.
`timescale 1ns/1ps
module tb_ldpc_uart_link;
    localparam int CPB   = 16;
    localparam int BIT_T = CPB * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx;
    logic       loop_en = 1'b0;
    logic       inj_line = 1'b1;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid, rx_corrected, rx_uncorrectable, rx_frame_err;

    int vec_count  = 0;
    int miscompares = 0;
    int pulse_cnt  = 0;
    int p0;

    logic        got;
    logic [7:0]  cap_data;
    logic        cap_corr, cap_unc, cap_ferr;
    logic [17:0] line_bits;
    logic [17:0] exp_line;

    logic [15:0] inj_cw   [4] = '{16'hDF0F, 16'hFF0E, 16'hFF0C, 16'h0000};
    logic        inj_stop [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  inj_data [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic        inj_corr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        inj_unc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        inj_ferr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;
    assign rx_line = loop_en ? tx : inj_line;

    always @(posedge clk) if (rx_valid) pulse_cnt <= pulse_cnt + 1;

    ldpc_uart_link #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .ECC_EN(1)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx),
        .rx(rx_line),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_corrected(rx_corrected),
        .rx_uncorrectable(rx_uncorrectable), .rx_frame_err(rx_frame_err)
    );

    task automatic check_value(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        vec_count++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic wait_rx();
        got = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                got      = 1'b1;
                cap_data = rx_data;
                cap_corr = rx_corrected;
                cap_unc  = rx_uncorrectable;
                cap_ferr = rx_frame_err;
                break;
            end
        end
        if (!got) check_value("rx_valid_timeout", 32'(got), 32'd1);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] d, input logic c, input logic u, input logic f);
        check_value({tag, "_data"}, 32'(cap_data), 32'(d));
        check_value({tag, "_corr"}, 32'(cap_corr), 32'(c));
        check_value({tag, "_unc"},  32'(cap_unc),  32'(u));
        check_value({tag, "_ferr"}, 32'(cap_ferr), 32'(f));
        $display("rx %s: data=0x%02h corr=%0b unc=%0b ferr=%0b", tag, cap_data, cap_corr, cap_unc, cap_ferr);
    endtask

    // Offers one byte, then scrambles tx_data to show it was latched; samples each line bit.
    task automatic send_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
        if (!tx_ready) check_value("tx_ready_wait", 32'(tx_ready), 32'd1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
        @(negedge clk);
        check_value("tx_ready_drop", 32'(tx_ready), 32'd0);
        #70;
        for (int k = 0; k < 18; k++) begin
            line_bits[k] = tx;
            #(BIT_T);
        end
        $display("tx 0x%02h: line=0x%05h", d, line_bits);
    endtask

    task automatic send_frame(input logic [15:0] cw, input logic stop_val);
        @(negedge clk);
        inj_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            inj_line = cw[i];
            repeat (CPB) @(negedge clk);
        end
        inj_line = stop_val;
        repeat (CPB) @(negedge clk);
        inj_line = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("rst_tx",       32'(tx),               32'd1);
        check_value("rst_tx_ready", 32'(tx_ready),         32'd1);
        check_value("rst_rx_data",  32'(rx_data),          32'd0);
        check_value("rst_rx_valid", 32'(rx_valid),         32'd0);
        check_value("rst_flags",    32'({rx_corrected, rx_uncorrectable, rx_frame_err}), 32'd0);

        // Loopback of 0xFF: codeword 0xFF0F framed by start 0 and stop 1.
        loop_en = 1'b1;
        p0 = pulse_cnt;
        fork
            send_tx(8'hFF);
            wait_rx();
        join
        exp_line = {1'b1, 16'hFF0F, 1'b0};
        check_value("line_ff", 32'(line_bits), 32'(exp_line));
        check_rx("lb_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_value("pulse_ff", 32'(pulse_cnt - p0), 32'd1);
        for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
        check_value("tx_ready_back", 32'(tx_ready), 32'd1);

        loop_en = 1'b0;
        for (int v = 0; v < 4; v++) begin
            fork
                send_frame(inj_cw[v], inj_stop[v]);
                wait_rx();
            join
            check_rx($sformatf("inj_%04h", inj_cw[v]), inj_data[v], inj_corr[v], inj_unc[v], inj_ferr[v]);
        end

        // Short low pulse on an idle line must not start a frame.
        p0 = pulse_cnt;
        @(negedge clk);
        inj_line = 1'b0;
        repeat (3) @(negedge clk);
        inj_line = 1'b1;
        repeat (60) @(negedge clk);
        check_value("glitch_no_valid", 32'(pulse_cnt - p0), 32'd0);
        $display("glitch: pulses=%0d", pulse_cnt - p0);

        // Reset during data bit 7 of a looped-back frame.
        loop_en = 1'b1;
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        for (int i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        #(8 * BIT_T + 74);
        rst = 1'b1;
        #1;
        check_value("rst_mid_tx", 32'(tx), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        p0 = pulse_cnt;
        @(negedge clk);
        check_value("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
        check_value("rst_mid_tx_line",  32'(tx),       32'd1);
        repeat (300) @(negedge clk);
        check_value("abort_no_valid", 32'(pulse_cnt - p0), 32'd0);
        $display("abort: pulses=%0d", pulse_cnt - p0);

        fork
            send_tx(8'h5A);
            wait_rx();
        join
        exp_line = {1'b1, 16'h5A9F, 1'b0};
        check_value("line_5a", 32'(line_bits), 32'(exp_line));
        check_rx("lb_5a", 8'h5A, 1'b0, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
